blvds_transmitter: RTL
======================

Name: blvds_transmitter

Overview:
- Frame generator for the 18-bit BLVDS link; the transmit end of the link whose receiver checks headers and epilogs and recomputes the frame checksum.
- Reads sample words from a show-ahead FIFO and wraps them into a frame: frame header, per-packet header, data and epilog, then frame epilog with checksum.
- Drives SYNC_SEQ on the line whenever no frame is in flight.

Parameters:
SYNC_LEN, 16, SYNC_SEQ words sent between start acceptance and frame head 1 (1..255)
FRAME_GAP, 128, minimum SYNC_SEQ words after frame epilog 2 before the next start is accepted; must be >= 100, the receiver's frame delay (1..255)

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-high
iSTART  in  1  frame request; sampled only in IDLE
iFORMAT  in  3  format field
iCHANNELS  in  4  channel mask
iPACK_SIZE  in  8  packet-size code
iPACK_NUM  in  8  packets per frame, P
iSAMPLE_NUM  in  16  sample field S; data words per packet = S+8
iFIFO_DATA  in  16  show-ahead FIFO head word
iFIFO_EMPTY  in  1  FIFO empty
oFIFO_RDREQ  out  1  FIFO pop
oDATA_BLVDS  out  18  line word, registered
oBUSY  out  1  frame in progress (SYNC through FEPI2)
oFRAME_DONE  out  1  one-cycle pulse on the cycle FEPI2 is on the line
oUNDERRUN  out  1  sticky; FIFO empty during DATA
oCFG_ERROR  out  1  one-cycle pulse; start rejected

Behaviour:
- Reset values: oDATA_BLVDS=18'h3FE00, all other outputs 0, state IDLE, frame counter 0.
- Service word format: {2'b11, tag[2:0], payload[12:0]}. Data word format: {2'b00, sample[15:0]}. SYNC_SEQ = 18'h3FE00.
- Tag and payload per word:
  - FH1: tag 000, payload {FORMAT, frame_cnt[1:0], PACK_NUM}
  - FH2: tag 001, payload {1'b0, CHANNELS, PACK_SIZE}
  - PH1: tag 010, payload {pack_cnt[4:0], S[15:8]}
  - PH2: tag 011, payload {5'b0, S[7:0]}
  - PE1: tag 110, payload {5'b0, pcrc[15:8]}
  - PE2: tag 111, payload {5'b0, pcrc[7:0]}
  - FE1: tag 100, payload {5'b0, fcrc[15:8]}
  - FE2: tag 101, payload {5'b0, fcrc[7:0]}
- Start acceptance: iSTART in IDLE latches all config inputs.
  - iPACK_NUM==0: start is rejected, oCFG_ERROR pulses, state stays IDLE.
  - Config inputs are ignored while oBUSY=1.
- States: IDLE -> SYNC (SYNC_LEN words) -> FH1 -> FH2 -> PH1 -> PH2 -> DATA (S+8 words) -> PE1 -> PE2.
  - From PE2: go to PH1 if packets sent < P, else FE1.
  - FE1 -> FE2 -> GAP (FRAME_GAP SYNC words) -> IDLE.
- Line output: each state's word appears on oDATA_BLVDS one cycle after the state is entered (registered). Words are back-to-back with no gaps.
- Frame length: 4 + P*(S+12) words.
- FIFO handshake: in DATA, oFIFO_RDREQ=!iFIFO_EMPTY in the same cycle; iFIFO_DATA is registered into the line word.
- Underrun: iFIFO_EMPTY in DATA sends data word 18'h00000, sets oUNDERRUN, and framing continues. oUNDERRUN clears only on the next accepted start.
- Counters:
  - frame_cnt (2 bits) increments after FE2 and wraps 3->0.
  - pack_cnt (5 bits) is 0 at the first packet of each frame, increments per packet, and wraps at 31.
- Frame checksum: fsum (16 bits, mod 2^16) accumulates the [15:0] field of every word FH1..PE2, including data words. It excludes SYNC and FE words. fcrc = ~fsum. fsum clears at start acceptance.
- Width rule: S+8 is computed in 17 bits, so S=16'hFFFF gives 65543 words.
- iRST mid-frame returns to IDLE at once; the line shows SYNC_SEQ from the next edge, and the partial frame is abandoned.

Optional Feature:
- Macro: TX_PACK_CRC_EN.
- Defined: pcrc = ~(sum of [15:0] of PH1, PH2 and that packet's data words), mod 2^16.
- Undefined: pcrc = 16'h0000.
- In both cases the PE words are included in fsum.

Test Plan:
- Baseline frame: macro off, P=1, S=0, FORMAT=0, CHANNELS=0, PACK_SIZE=0, FIFO holding 8 words of 0x0001 -> after 16 SYNC words the line shows 3_0001, 3_2000, 3_4000, 3_6000, 8 words of 0_0001, 3_C000, 3_E000, 3_809F, 3_A0F6. oFRAME_DONE pulses with the last word.
- Multi-packet frame: P=3, S=4 -> 3 packets of 12 data words each, PH1 pack_cnt = 0,1,2, exactly one FE pair, frame length 52 words.
- Frame counter: 5 consecutive frames -> FH1 frame_cnt field reads 0,1,2,3,0, and each inter-frame gap is >=128 SYNC words.
- Underrun: FIFO empty for the 3rd data word -> that word is 18'h00000, oUNDERRUN=1, total word count unchanged, oUNDERRUN cleared by the next start.
- Rejected start: iPACK_NUM=0 with iSTART -> oCFG_ERROR pulses for 1 cycle, oBUSY stays 0, line stays at 3FE00.
- Reset during DATA: iRST asserted -> line returns to 3FE00 and oBUSY=0; the next start produces a clean frame with frame_cnt=0.

Source files
------------

// File: rtl/blvds_transmitter.sv
// blvds_transmitter: builds SYNC / header / data / epilog frames for the 18-bit BLVDS link.
// Optional per-packet checksum in the PE words: define TX_PACK_CRC_EN.
module blvds_transmitter #(
    parameter int SYNC_LEN  = 16,
    parameter int FRAME_GAP = 128
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [2:0]  iFORMAT,
    input  logic [3:0]  iCHANNELS,
    input  logic [7:0]  iPACK_SIZE,
    input  logic [7:0]  iPACK_NUM,
    input  logic [15:0] iSAMPLE_NUM,
    input  logic [15:0] iFIFO_DATA,
    input  logic        iFIFO_EMPTY,
    output logic        oFIFO_RDREQ,
    output logic [17:0] oDATA_BLVDS,
    output logic        oBUSY,
    output logic        oFRAME_DONE,
    output logic        oUNDERRUN,
    output logic        oCFG_ERROR,
    output logic [3:0]  oDBG_STATE
);

    localparam logic [17:0] SYNC_SEQ = 18'h3FE00;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        SYNC = 4'd1,
        FH1  = 4'd2,
        FH2  = 4'd3,
        PH1  = 4'd4,
        PH2  = 4'd5,
        DATA = 4'd6,
        PE1  = 4'd7,
        PE2  = 4'd8,
        FE1  = 4'd9,
        FE2  = 4'd10,
        GAP  = 4'd11
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic [2:0]  cfgFormat;
    logic [3:0]  cfgChannels;
    logic [7:0]  cfgPackSize;
    logic [7:0]  cfgPackNum;
    logic [15:0] cfgSampleNum;

    logic [7:0]  syncCnt;
    logic [16:0] dataCnt;
    logic [16:0] dataLen;
    logic [7:0]  packIdx;
    logic [1:0]  frameCnt;
    logic [15:0] fsum;
    logic [15:0] fcrc;
    logic [15:0] pcrc;

    logic        startOk;
    logic        startBad;
    logic        lastSync;
    logic        lastGap;
    logic        lastData;
    logic        lastPack;
    logic        inFrameSum;
    logic [17:0] wordNext;

    function automatic logic [17:0] svcWord(input logic [2:0] tag, input logic [12:0] payload);
        return {2'b11, tag, payload};
    endfunction

    assign startOk    = (state == IDLE) && iSTART && (iPACK_NUM != 8'd0);
    assign startBad   = (state == IDLE) && iSTART && (iPACK_NUM == 8'd0);
    // 17-bit length so a sample field of FFFF still yields 65543 data words.
    assign dataLen    = {1'b0, cfgSampleNum} + 17'd8;
    assign lastSync   = (syncCnt == 8'(SYNC_LEN - 1));
    assign lastGap    = (syncCnt == 8'(FRAME_GAP - 1));
    assign lastData   = (dataCnt == dataLen - 17'd1);
    assign lastPack   = ((packIdx + 8'd1) == cfgPackNum);
    assign inFrameSum = (state inside {FH1, FH2, PH1, PH2, DATA, PE1, PE2});
    assign fcrc       = ~fsum;

    assign oBUSY      = (state != IDLE) && (state != GAP);
    assign oDBG_STATE = state;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (startOk) stateNext = SYNC;
            SYNC:    if (lastSync) stateNext = FH1;
            FH1:     stateNext = FH2;
            FH2:     stateNext = PH1;
            PH1:     stateNext = PH2;
            PH2:     stateNext = DATA;
            DATA:    if (lastData) stateNext = PE1;
            PE1:     stateNext = PE2;
            PE2:     stateNext = lastPack ? FE1 : PH1;
            FE1:     stateNext = FE2;
            FE2:     stateNext = GAP;
            GAP:     if (lastGap) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // FIFO handshake: show-ahead, so the head word is valid whenever iFIFO_EMPTY is low;
    // oFIFO_RDREQ pops it in the same cycle it is registered onto the line.
    always_comb begin
        wordNext    = SYNC_SEQ;
        oFIFO_RDREQ = 1'b0;
        unique case (state)
            FH1:  wordNext = svcWord(3'b000, {cfgFormat, frameCnt, cfgPackNum});
            FH2:  wordNext = svcWord(3'b001, {1'b0, cfgChannels, cfgPackSize});
            PH1:  wordNext = svcWord(3'b010, {packIdx[4:0], cfgSampleNum[15:8]});
            PH2:  wordNext = svcWord(3'b011, {5'b0, cfgSampleNum[7:0]});
            DATA: begin
                oFIFO_RDREQ = !iFIFO_EMPTY;
                wordNext    = iFIFO_EMPTY ? 18'h00000 : {2'b00, iFIFO_DATA};
            end
            PE1:  wordNext = svcWord(3'b110, {5'b0, pcrc[15:8]});
            PE2:  wordNext = svcWord(3'b111, {5'b0, pcrc[7:0]});
            FE1:  wordNext = svcWord(3'b100, {5'b0, fcrc[15:8]});
            FE2:  wordNext = svcWord(3'b101, {5'b0, fcrc[7:0]});
            default: wordNext = SYNC_SEQ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA_BLVDS <= SYNC_SEQ;
            oFRAME_DONE <= 1'b0;
            oCFG_ERROR  <= 1'b0;
        end else begin
            oDATA_BLVDS <= wordNext;
            oFRAME_DONE <= (state == FE2);
            oCFG_ERROR  <= startBad;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cfgFormat    <= '0;
            cfgChannels  <= '0;
            cfgPackSize  <= '0;
            cfgPackNum   <= '0;
            cfgSampleNum <= '0;
        end else if (startOk) begin
            cfgFormat    <= iFORMAT;
            cfgChannels  <= iCHANNELS;
            cfgPackSize  <= iPACK_SIZE;
            cfgPackNum   <= iPACK_NUM;
            cfgSampleNum <= iSAMPLE_NUM;
        end
    end

    // One counter times both the leading SYNC run and the trailing gap.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            syncCnt <= '0;
        end else if ((state == SYNC && !lastSync) || (state == GAP && !lastGap)) begin
            syncCnt <= syncCnt + 8'd1;
        end else begin
            syncCnt <= '0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            dataCnt <= '0;
        end else if (state == DATA && !lastData) begin
            dataCnt <= dataCnt + 17'd1;
        end else begin
            dataCnt <= '0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            packIdx  <= '0;
            frameCnt <= '0;
        end else begin
            if (startOk) begin
                packIdx <= '0;
            end else if (state == PE2) begin
                packIdx <= packIdx + 8'd1;
            end
            if (state == FE2) begin
                frameCnt <= frameCnt + 2'd1;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fsum      <= '0;
            oUNDERRUN <= 1'b0;
        end else if (startOk) begin
            fsum      <= '0;
            oUNDERRUN <= 1'b0;
        end else begin
            if (inFrameSum) begin
                fsum <= fsum + wordNext[15:0];
            end
            if (state == DATA && iFIFO_EMPTY) begin
                oUNDERRUN <= 1'b1;
            end
        end
    end

`ifdef TX_PACK_CRC_EN
    logic [15:0] psum;

    assign pcrc = ~psum;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            psum <= '0;
        end else if (startOk || state == PE2) begin
            psum <= '0;
        end else if (state inside {PH1, PH2, DATA}) begin
            psum <= psum + wordNext[15:0];
        end
    end
`else
    assign pcrc = 16'h0000;
`endif

endmodule
